// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Next-PC and fetch-stall controller. Chooses the sequential,
//                branch or jump target for the PC register, holds the front
//                end on load-use hazards and instruction-memory wait, and
//                produces IF/ID hold/flush and ID/EX bubble controls.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          PC_STEP  = 4,
    parameter int          CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  pc_value,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic          idex_mem_read,
    input  logic [4:0]    idex_rt,
    input  logic [4:0]    ifid_rs,
    input  logic [4:0]    ifid_rt,
    input  logic          branch_taken,
    input  logic [N-1:0]  branch_target,
    input  logic          jump,
    input  logic [N-1:0]  jump_target,
    output logic [N-1:0]  new_pc,
    output logic          pc_enable,
    output logic          ifid_enable,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic [CW-1:0] stall_count
);

    localparam logic [N-1:0] PC_INC = N'(PC_STEP);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_LU_HOLD   = 2'd1,
        S_IMEM_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic [N-1:0]    pend_target_q, pend_target_d;
    logic [CW-1:0]   stall_count_q, stall_count_d;

    logic [N-1:0]    seq_pc;
    logic            redir;
    logic [N-1:0]    redir_tgt;
    logic            lu_hz;

    // Shared decode terms: sequential PC, redirect selection, load-use hazard
    always_comb begin
        seq_pc    = pc_value + PC_INC;
        redir     = branch_taken | jump;
        redir_tgt = branch_taken ? branch_target : jump_target;
        lu_hz     = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

    // Next-state and output decode
    always_comb begin
        new_pc        = seq_pc;
        pc_enable     = 1'b0;
        ifid_enable   = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        imem_req      = 1'b1;
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        stall_count_d = stall_count_q;

        if (!reset) begin
            new_pc      = RESET_PC;
            imem_req    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state_q)
                S_IMEM_WAIT: begin
                    idex_bubble = 1'b1;
                    if (imem_ack) begin
                        pc_enable   = 1'b1;
                        ifid_enable = 1'b1;
                        state_d     = S_RUN;
                        if (redir || pend_valid_q) begin
                            new_pc       = redir ? redir_tgt : pend_target_q;
                            ifid_flush   = 1'b1;
                            pend_valid_d = 1'b0;
                        end
                    end else if (redir) begin
                        // Most recent redirect seen while waiting wins
                        pend_valid_d  = 1'b1;
                        pend_target_d = redir_tgt;
                    end
                end
                // RUN and LU_HOLD share decode; the hold state masks the
                // hazard so one ID instruction gets at most one bubble.
                // The unused code 3 falls here and behaves as RUN.
                default: begin
                    state_d = S_RUN;
                    if (!imem_ack) begin
                        idex_bubble = 1'b1;
                        state_d     = S_IMEM_WAIT;
                        if (redir) begin
                            pend_valid_d  = 1'b1;
                            pend_target_d = redir_tgt;
                        end
                    end else if (redir) begin
                        new_pc      = redir_tgt;
                        pc_enable   = 1'b1;
                        ifid_enable = 1'b1;
                        ifid_flush  = 1'b1;
                    end else if (lu_hz && (state_q != S_LU_HOLD)) begin
                        idex_bubble = 1'b1;
                        state_d     = S_LU_HOLD;
                    end else begin
                        pc_enable   = 1'b1;
                        ifid_enable = 1'b1;
                    end
                end
            endcase

            if (!pc_enable && (stall_count_q != {CW{1'b1}})) begin
                stall_count_d = stall_count_q + CW'(1);
            end
        end
    end

    // State, pending redirect and stall counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_RUN;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire
